// File: rtl/can_tx_scheduler.sv
// can_tx_scheduler: lowest-ID-first CAN TX mailbox arbiter with abort and error retry handling.
// Define CAN_TX_RETRY_LIMIT_EN to fail a frame after RETRY_MAX transmit errors (otherwise it retries forever).
module can_tx_scheduler #(
   parameter int NUM_MB    = 4,
   parameter int ID_W      = 11,
   parameter int RETRY_MAX = 8,
   localparam int SEL_W    = $clog2(NUM_MB)
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic [NUM_MB-1:0]      mb_req_i,
   input  logic [NUM_MB*ID_W-1:0] mb_id_i,
   input  logic [NUM_MB-1:0]      mb_abort_i,
   input  logic                   bus_idle_i,
   input  logic                   tx_done_i,
   input  logic                   tx_arb_lost_i,
   input  logic                   tx_err_i,
   output logic                   tx_start_o,
   output logic [SEL_W-1:0]       tx_sel_o,
   output logic [ID_W-1:0]        tx_id_o,
   output logic [NUM_MB-1:0]      mb_ack_o,
   output logic [NUM_MB-1:0]      mb_fail_o,
   output logic                   busy_o
);
   typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
   state_t state, state_nxt;
   logic [NUM_MB-1:0] blocked, elig, sel_oh, ack_set, fail_set;
   logic found, abort_flag, ab, done_ev, err_ev, lost_ev, limit, fin_fail;
   logic [SEL_W-1:0] win_sel;
   logic [ID_W-1:0] win_id;

   if (NUM_MB < 2 || NUM_MB > 8 || RETRY_MAX < 1 || RETRY_MAX > 15) begin : g_bad_param
      $error("can_tx_scheduler: parameter out of range");
   end

   // strict compare keeps the lowest index on equal IDs
   always_comb begin
      elig = mb_req_i & ~blocked & ~mb_abort_i;
      found = 1'b0;
      win_sel = '0;
      win_id = '0;
      for (int k = 0; k < NUM_MB; k++)
         if (elig[k] && (!found || mb_id_i[k*ID_W +: ID_W] < win_id)) begin
            found = 1'b1;
            win_sel = SEL_W'(k);
            win_id = mb_id_i[k*ID_W +: ID_W];
         end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i) state <= IDLE;
      else state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (found && bus_idle_i) state_nxt = START;
         START:   state_nxt = WAIT;
         WAIT:    if (tx_done_i || tx_err_i || tx_arb_lost_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tx_start_o = state == START;
      busy_o = state != IDLE;
   end

   always_comb begin
      sel_oh = NUM_MB'(1) << tx_sel_o;
      ab = abort_flag || mb_abort_i[tx_sel_o];
      done_ev = state == WAIT && tx_done_i;
      err_ev = state == WAIT && !tx_done_i && tx_err_i;
      lost_ev = state == WAIT && !tx_done_i && !tx_err_i && tx_arb_lost_i;
      fin_fail = ((err_ev || lost_ev) && ab) || limit;
      ack_set = done_ev ? sel_oh : '0;
      fail_set = (fin_fail ? sel_oh : '0) | (mb_abort_i & mb_req_i & ~blocked & (busy_o ? ~sel_oh : '1));
   end

`ifdef CAN_TX_RETRY_LIMIT_EN
   logic [3:0] cnt [NUM_MB];
   assign limit = err_ev && !ab && ({1'b0, cnt[tx_sel_o]} + 5'd1 == 5'(RETRY_MAX));
   always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i)
         for (int k = 0; k < NUM_MB; k++) cnt[k] <= '0;
      else
         for (int k = 0; k < NUM_MB; k++)
            if (ack_set[k] || fail_set[k]) cnt[k] <= '0;
            else if (err_ev && tx_sel_o == SEL_W'(k)) cnt[k] <= cnt[k] + 4'd1;
`else
   assign limit = 1'b0;
`endif

   always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i) begin
         tx_sel_o <= '0;
         tx_id_o <= '0;
         abort_flag <= 1'b0;
         blocked <= '0;
         mb_ack_o <= '0;
         mb_fail_o <= '0;
      end else begin
         if (state == IDLE && state_nxt == START) begin
            tx_sel_o <= win_sel;
            tx_id_o <= win_id;
         end
         abort_flag <= state != IDLE && state_nxt != IDLE && ab;
         blocked <= ack_set | fail_set | (blocked & mb_req_i);
         mb_ack_o <= ack_set;
         mb_fail_o <= fail_set;
      end
endmodule

// File: tb/tb_can_tx_scheduler.sv
// tb_can_tx_scheduler: scoreboard bench; expected starts and ack/fail pulses are queued as stimulus is driven.
module tb_can_tx_scheduler;
   localparam int N = 4, W = 11;
   logic clk = 1'b0, rst;
   logic [N-1:0] req = '0, abort = '0;
   logic [N*W-1:0] ids = '0;
   logic bus_idle = 1'b0, done = 1'b0, lost = 1'b0, err = 1'b0;
   logic start, busy;
   logic [1:0] sel;
   logic [W-1:0] id;
   logic [N-1:0] ack, fail;
   int n_tests = 0, n_fail = 0;
   logic [12:0] sq[$];
   logic [7:0] pq[$];

   always #5 clk = ~clk;

   can_tx_scheduler #(.NUM_MB(N), .ID_W(W), .RETRY_MAX(3)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .mb_req_i(req), .mb_id_i(ids), .mb_abort_i(abort),
      .bus_idle_i(bus_idle), .tx_done_i(done), .tx_arb_lost_i(lost), .tx_err_i(err),
      .tx_start_o(start), .tx_sel_o(sel), .tx_id_o(id), .mb_ack_o(ack), .mb_fail_o(fail),
      .busy_o(busy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_id(input int k, input logic [W-1:0] v);
      ids[k*W +: W] = v;
   endtask

   task automatic wait_start(input string tag);
      for (int n = 0; n < 20 && !start; n++) step();
      if (!start) check(tag, start, 1);
   endtask

   task automatic complete(input logic d, input logic e, input logic l);
      done = d;
      err = e;
      lost = l;
      step();
      done = 1'b0;
      err = 1'b0;
      lost = 1'b0;
   endtask

   // scoreboard side: every start and every ack/fail pulse must match the head of its queue
   always @(negedge clk)
      if (!rst) begin
         if (start) begin
            if (sq.size() == 0) check("start_unexp", start, 0);
            else check("start_sel_id", {sel, id}, sq.pop_front());
         end
         if ((ack | fail) != 0) begin
            if (pq.size() == 0) check("pulse_unexp", {ack, fail}, 0);
            else check("pulse_ack_fail", {ack, fail}, pq.pop_front());
         end
      end

   initial begin
      rst = 1'b1;
      step(2);
      check("rst_start", start, 0);
      check("rst_busy", busy, 0);
      check("rst_sel", sel, 0);
      check("rst_id", id, 0);
      check("rst_ack", ack, 0);
      check("rst_fail", fail, 0);
      rst = 1'b0;
      step();
      // lowest ID wins, tie goes to lowest index
      set_id(0, 11'h120); set_id(1, 11'h0A0); set_id(2, 11'h0A0); set_id(3, 11'h7FF);
      req = 4'b0111;
      step();
      check("no_bus_idle", busy, 0);
      sq.push_back({2'd1, 11'h0A0});
      bus_idle = 1'b1;
      step();
      check("s1_start_lat", start, 1);
      bus_idle = 1'b0;
      step();
      check("s1_start_1cyc", start, 0);
      check("s1_busy", busy, 1);
      check("s1_sel_hold", sel, 1);
      check("s1_id_hold", id, 11'h0A0);
      pq.push_back({4'b0010, 4'b0000});
      complete(1, 0, 0);
      step();
      check("s1_ack_gone", ack, 0);
      // acked mailbox is not re-selected while its request stays high
      req = 4'b0001;
      sq.push_back({2'd0, 11'h120});
      bus_idle = 1'b1;
      wait_start("s2_start_tmo");
      bus_idle = 1'b0;
      step();
      pq.push_back({4'b0001, 4'b0000});
      complete(1, 0, 0);
      check("s2_ack_mb0", ack, 4'b0001);
      step();
      check("s2_ack_1cyc", ack, 0);
      bus_idle = 1'b1;
      step(6);
      check("s2_no_reselect", busy, 0);
      req = '0; bus_idle = 1'b0;
      step();
      // arbitration lost, then a higher-priority request wins the retry
      set_id(0, 11'h300); set_id(2, 11'h050);
      req = 4'b0001;
      sq.push_back({2'd0, 11'h300});
      bus_idle = 1'b1;
      wait_start("s3_start_tmo");
      step();
      req = 4'b0101;
      sq.push_back({2'd2, 11'h050});
      complete(0, 0, 1);
      wait_start("s3_restart_tmo");
      check("s3_sel", sel, 2);
      bus_idle = 1'b0;
      step();
      pq.push_back({4'b0100, 4'b0000});
      complete(1, 0, 0);
      sq.push_back({2'd0, 11'h300});
      bus_idle = 1'b1;
      wait_start("s3_mb0_tmo");
      bus_idle = 1'b0;
      step();
      pq.push_back({4'b0001, 4'b0000});
      complete(1, 0, 0);
      req = '0;
      step();
      // repeated errors on mb1
      set_id(1, 11'h111);
      req = 4'b0010;
      bus_idle = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sq.push_back({2'd1, 11'h111});
         wait_start("s4_start_tmo");
         step();
`ifdef CAN_TX_RETRY_LIMIT_EN
         if (i == 2) pq.push_back({4'b0000, 4'b0010});
`endif
         complete(0, 1, 0);
      end
`ifdef CAN_TX_RETRY_LIMIT_EN
      step(4);
      check("s4_no_retry", busy, 0);
`else
      sq.push_back({2'd1, 11'h111});
      wait_start("s4_4th_tmo");
      check("s4_4th_sel", sel, 1);
      bus_idle = 1'b0;
      step();
      pq.push_back({4'b0010, 4'b0000});
      complete(1, 0, 0);
`endif
      req = '0; bus_idle = 1'b0;
      step();
      // abort while in flight, then error: fail without restart
      set_id(3, 11'h222);
      req = 4'b1000;
      bus_idle = 1'b1;
      sq.push_back({2'd3, 11'h222});
      wait_start("s5_start_tmo");
      step();
      abort = 4'b1000;
      step();
      abort = '0;
      check("s5_abort_deferred", fail, 0);
      pq.push_back({4'b0000, 4'b1000});
      complete(0, 1, 0);
      step(5);
      check("s5_no_restart", busy, 0);
      req = '0;
      step();
      // done and error together: ack only
      set_id(2, 11'h333);
      req = 4'b0100;
      sq.push_back({2'd2, 11'h333});
      wait_start("s5b_start_tmo");
      step();
      pq.push_back({4'b0100, 4'b0000});
      complete(1, 1, 0);
      check("s5b_no_fail", fail, 0);
      req = '0; bus_idle = 1'b0;
      step();
      // abort of a pending, idle mailbox
      req = 4'b0011;
      step();
      pq.push_back({4'b0000, 4'b0001});
      abort = 4'b0001;
      step();
      abort = '0;
      check("idle_abort_fail", fail, 4'b0001);
      step();
      check("idle_abort_1cyc", fail, 0);
      // reset in WAIT discards the frame
      sq.push_back({2'd1, 11'h111});
      bus_idle = 1'b1;
      wait_start("s6_start_tmo");
      bus_idle = 1'b0;
      step();
      check("s6_in_wait", busy, 1);
      #2 rst = 1'b1;
      #1;
      check("s6_rst_start", start, 0);
      check("s6_rst_busy", busy, 0);
      check("s6_rst_sel", sel, 0);
      check("s6_rst_id", id, 0);
      check("s6_rst_ack", ack, 0);
      check("s6_rst_fail", fail, 0);
      step();
      rst = 1'b0;
      step(5);
      check("s6_no_pulse", {ack, fail}, 0);
      check("sq_left", sq.size(), 0);
      check("pq_left", pq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/can_tx_scheduler.md
CAN_TX_SCHEDULER -- requirements
Module: can_tx_scheduler

Interface
REQ-001 SHALL have parameter NUM_MB, default 4, number of TX mailboxes (2..8).
REQ-002 SHALL have parameter ID_W, default 11, CAN identifier width.
REQ-003 SHALL have parameter RETRY_MAX, default 8, error retries before failure; used only with the macro in REQ-026.
REQ-004 SHALL have port wb_clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port wb_rst_i, input, 1, reset; asynchronous and active-high.
REQ-006 SHALL have port mb_req_i, input, NUM_MB, level per mailbox meaning a frame is pending.
REQ-007 SHALL have port mb_id_i, input, NUM_MB*ID_W, flattened IDs; mailbox k at bits [k*ID_W +: ID_W].
REQ-008 SHALL have port mb_abort_i, input, NUM_MB, one-cycle abort pulse per mailbox.
REQ-009 SHALL have port bus_idle_i, input, 1, CAN core reports bus idle.
REQ-010 SHALL have port tx_done_i, input, 1, pulse: frame sent and acknowledged.
REQ-011 SHALL have port tx_arb_lost_i, input, 1, pulse: bus arbitration lost.
REQ-012 SHALL have port tx_err_i, input, 1, pulse: bit/ack/form error during TX.
REQ-013 SHALL have port tx_start_o, output, 1, one-cycle start pulse to CAN core.
REQ-014 SHALL have port tx_sel_o, output, clog2(NUM_MB), in-flight mailbox index.
REQ-015 SHALL have port tx_id_o, output, ID_W, in-flight identifier.
REQ-016 SHALL have port mb_ack_o, output, NUM_MB, one-cycle success pulse.
REQ-017 SHALL have port mb_fail_o, output, NUM_MB, one-cycle failure pulse (abort or retry limit).
REQ-018 SHALL have port busy_o, output, 1, high in START and WAIT.

Function
REQ-019 SHALL implement FSM IDLE -> START -> WAIT -> IDLE.
REQ-020 SHALL, in IDLE when any mailbox is eligible and bus_idle_i=1, latch the winner: lowest mb_id value; tie -> lowest index; go to START, so tx_start_o rises the next cycle.
REQ-021 SHALL define eligible as mb_req_i[k]=1 and blocked[k]=0; blocked[k] sets on mb_ack_o[k] or mb_fail_o[k], clears when mb_req_i[k]=0.
REQ-022 SHALL hold tx_sel_o and tx_id_o stable from START through WAIT; START lasts exactly one cycle, then WAIT.
REQ-023 SHALL in WAIT: tx_done_i -> mb_ack_o[sel] pulse next cycle, clear retry count, IDLE; tx_arb_lost_i -> IDLE with no count change (re-arbitrate); tx_err_i -> increment retry count of sel, IDLE.
REQ-024 SHALL on simultaneous done/err/arb_lost apply priority done > err > arb_lost; completion pulses outside WAIT are ignored.
REQ-025 SHALL on mb_abort_i[k] for non-in-flight pending k pulse mb_fail_o[k] next cycle; for in-flight k record abort: later done -> ack, later err/arb_lost -> fail (no retry); mb_req_i drop while in flight does not affect the transfer.

Configuration
REQ-026 SHALL, with CAN_TX_RETRY_LIMIT_EN defined, keep a 4-bit per-mailbox error count and on the error that makes it reach RETRY_MAX pulse mb_fail_o[sel] and clear the count; without it, no counters exist and errored frames retry indefinitely.

Reset
REQ-027 SHALL on wb_rst_i=1, asynchronously: state IDLE, all outputs 0, blocked, abort flags and retry counts 0.
REQ-028 SHALL on reset mid-transfer discard the in-flight frame with no ack/fail pulse.

Verification
REQ-029 Bench SHALL check: req=4'b0111, ids 0x120/0x0A0/0x0A0, bus_idle=1 -> tx_start_o one cycle later, tx_sel_o=1, tx_id_o=0x0A0.
REQ-030 Bench SHALL check: in-flight mb0, tx_done_i -> mb_ack_o=4'b0001 next cycle only; mb0 not re-selected while mb_req_i[0] stays high.
REQ-031 Bench SHALL check: tx_arb_lost_i, then higher-priority mb2 request -> next tx_start_o carries tx_sel_o=2.
REQ-032 Bench SHALL check: with CAN_TX_RETRY_LIMIT_EN, RETRY_MAX=3, three tx_err_i on mb1 -> mb_fail_o=4'b0010 after third; without macro -> fourth tx_start_o for mb1.
REQ-033 Bench SHALL check: abort mb3 in WAIT, then tx_err_i -> mb_fail_o=4'b1000, no restart; same-cycle done+err -> ack only.
REQ-034 Bench SHALL check: wb_rst_i asserted in WAIT -> all outputs 0 immediately, no pulses after release.
